// File: rtl/rf_buffer_writer.sv
// rtl/rf_buffer_writer.sv - double-buffered frame memory and config bank writer driven by decoder strobes
module rf_buffer_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int CFG_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        inst_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [CFG_AW-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              front_sel,
    output logic              busy,
    output logic              wr_done,
    output logic              err_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CFG_N = 1 << CFG_AW;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;

    state_t              state;
    logic                cs_q;
    logic                rise;
    logic                clr_code;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic [1:0]          inst_r;
    logic [ADDR_W-1:0]   clr_cnt;

    logic [DATA_W-1:0]   bank_a [DEPTH];
    logic [DATA_W-1:0]   bank_b [DEPTH];
    logic [DATA_W-1:0]   cfg_regs [CFG_N];

    logic                we_a;
    logic                we_b;
    logic                we_cfg;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;

    assign rise     = cs_in & ~cs_q;
    assign clr_code = (inst_in == 2'b00) && (addr_in[CFG_AW-1:0] == CFG_AW'(1));

    // Decode this cycle's memory writes from the current state and latched command.
    always_comb begin
        we_a   = 1'b0;
        we_b   = 1'b0;
        we_cfg = 1'b0;
        w_addr = addr_r;
        w_data = data_r;
        case (state)
            WRITE: begin
                case (inst_r)
                    2'b11: begin
                        we_a = 1'b1;
                        we_b = 1'b1;
                    end
                    2'b10: begin
                        if (front_sel) we_b = 1'b1;
                        else           we_a = 1'b1;
                    end
                    2'b01: we_cfg = 1'b1;
                    default: ;
                endcase
            end
            CLEAR: begin
                w_addr = clr_cnt;
                w_data = '0;
                // The back bank is the one not shown; front_sel is frozen while clearing.
                if (front_sel) we_a = 1'b1;
                else           we_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Command sequencer: edge detect, command latch, swap and clear sweep, status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cs_q      <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            inst_r    <= '0;
            clr_cnt   <= '0;
            front_sel <= 1'b0;
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            cs_q    <= cs_in;
            wr_done <= 1'b0;
            if (rise && state != IDLE) err_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise) begin
                        addr_r <= addr_in;
                        data_r <= data_in;
                        inst_r <= inst_in;
                        busy   <= 1'b1;
                        state  <= clr_code ? CLEAR : WRITE;
                    end
                end
                WRITE: begin
                    if (inst_r == 2'b00 && addr_r[CFG_AW-1:0] == '0)
                        front_sel <= ~front_sel;
                    wr_done <= 1'b1;
                    state   <= DONE;
                end
                CLEAR: begin
                    if (&clr_cnt) begin
                        clr_cnt <= '0;
                        wr_done <= 1'b1;
                        state   <= DONE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame buffer RAM writes; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_a) bank_a[w_addr] <= w_data;
        if (we_b) bank_b[w_addr] <= w_data;
    end

    // Display read port on the current front bank, read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= front_sel ? bank_b[rd_addr] : bank_a[rd_addr];
    end

    // Config register bank with its registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CFG_N; i++) cfg_regs[i] <= '0;
            cfg_data <= '0;
        end else begin
            if (we_cfg) cfg_regs[addr_r[CFG_AW-1:0]] <= data_r;
            cfg_data <= cfg_regs[cfg_addr];
        end
    end

endmodule
